// File: rtl/cnn_buf_pkg.sv
// cnn_buf_pkg: shared write-FSM encoding and width helper for the layer input buffer
package cnn_buf_pkg;
  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/layer_buf_ram.sv
// layer_buf_ram: simple dual-port RAM, synchronous write, registered read-first read
module layer_buf_ram #(
  parameter int DATA_W = 512,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [2**AW];
  logic [DATA_W-1:0] r_rdata;
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  always_ff @(posedge clk)
    if (rst) r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  assign o_rdata = r_rdata;
endmodule

// File: rtl/layer_input_buffer.sv
// layer_input_buffer: ping-pong feature-map buffer between two CNN layers,
// one bank filling while the other is read, with start/release handshake.
module layer_input_buffer
  import cnn_buf_pkg::*;
#(
  parameter int DATA_W    = 512,
  parameter int ADDR_W    = 7,
  parameter int NUM_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              conv_start,
  output logic              start_ready,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] d_in,
  output logic              write_complete,
  output logic              rd_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] d_out,
  input  logic              rd_release,
  output logic              err_stray_wr,
  output logic              err_addr
);
  localparam int CW = clog2(NUM_WORDS + 1);
  localparam logic [ADDR_W:0] NW   = (ADDR_W+1)'(NUM_WORDS);
  localparam logic [CW-1:0]   LAST = CW'(NUM_WORDS - 1);
  state_t            r_state, w_next;
  logic              r_wr_bank, r_rd_bank, r_wc, r_err_stray, r_err_addr;
  logic [1:0]        r_valid;
  logic [CW-1:0]     r_wr_count;
  logic              w_addr_ok, w_start, w_wr_acc, w_last, w_rel;
  logic [1:0]        w_set, w_clr;
  assign start_ready = (r_state == IDLE) && !r_valid[r_wr_bank];
  assign rd_ready    = r_valid[r_rd_bank];
  assign w_addr_ok   = {1'b0, wr_addr} < NW;
  assign w_start     = conv_start && start_ready;
  assign w_wr_acc    = (r_state == FILL) && wr_en && w_addr_ok;
  assign w_last      = w_wr_acc && (r_wr_count == LAST);
  assign w_rel       = rd_release && rd_ready;
  // completion and release always hit different banks, so both masks apply together
  assign w_set       = w_last ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign w_clr       = w_rel  ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = w_start ? FILL : IDLE;
    else                 w_next = w_last  ? IDLE : FILL;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state     <= IDLE;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_valid     <= 2'b00;
      r_wr_count  <= '0;
      r_wc        <= 1'b0;
      r_err_stray <= 1'b0;
      r_err_addr  <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_wr_count  <= w_start ? '0 : (w_wr_acc ? r_wr_count + 1'b1 : r_wr_count);
      r_wc        <= w_last;
      r_wr_bank   <= r_wr_bank ^ w_last;
      r_rd_bank   <= r_rd_bank ^ w_rel;
      r_valid     <= (r_valid | w_set) & ~w_clr;
      r_err_stray <= r_err_stray | (wr_en && r_state == IDLE);
      r_err_addr  <= r_err_addr | (wr_en && r_state == FILL && !w_addr_ok);
    end
  assign write_complete = r_wc;
  assign err_stray_wr   = r_err_stray;
  assign err_addr       = r_err_addr;
  layer_buf_ram #(.DATA_W(DATA_W), .AW(ADDR_W + 1)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_wr_acc),
    .i_waddr ({r_wr_bank, wr_addr}),
    .i_wdata (d_in),
    .i_re    (rd_en),
    .i_raddr ({r_rd_bank, rd_addr}),
    .o_rdata (d_out)
  );
endmodule

// File: tb/tb_layer_input_buffer.sv
// tb_layer_input_buffer: scenario tasks with a read-data scoreboard queue
module tb_layer_input_buffer;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, conv_start, wr_en, rd_en, rd_release;
  logic [6:0] wr_addr, rd_addr;
  logic [511:0] d_in, d_out;
  logic start_ready, write_complete, rd_ready, err_stray_wr, err_addr;
  logic rst2, conv_start2, wr_en2, rd_en2, rd_release2;
  logic [3:0] wr_addr2, rd_addr2;
  logic [63:0] d_in2, d_out2;
  logic start_ready2, write_complete2, rd_ready2, err_stray_wr2, err_addr2;
  logic [511:0] q[$];
  logic [511:0] exp_v;
  int errors = 0, checks = 0;

  layer_input_buffer u_dut (
    .clk(clk), .rst(rst), .conv_start(conv_start), .start_ready(start_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .d_in(d_in), .write_complete(write_complete),
    .rd_ready(rd_ready), .rd_en(rd_en), .rd_addr(rd_addr), .d_out(d_out),
    .rd_release(rd_release), .err_stray_wr(err_stray_wr), .err_addr(err_addr));

  layer_input_buffer #(.DATA_W(64), .ADDR_W(4), .NUM_WORDS(9)) u_dut2 (
    .clk(clk), .rst(rst2), .conv_start(conv_start2), .start_ready(start_ready2),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .d_in(d_in2), .write_complete(write_complete2),
    .rd_ready(rd_ready2), .rd_en(rd_en2), .rd_addr(rd_addr2), .d_out(d_out2),
    .rd_release(rd_release2), .err_stray_wr(err_stray_wr2), .err_addr(err_addr2));

  task automatic start1();
    conv_start = 1; @(negedge clk); conv_start = 0;
  endtask
  task automatic wr1(input int a, input int v);
    wr_en = 1; wr_addr = 7'(a); d_in = 512'(v); @(negedge clk); wr_en = 0;
  endtask
  task automatic rd1(input int a, input int v);
    rd_en = 1; rd_addr = 7'(a); q.push_back(512'(v)); @(negedge clk); rd_en = 0;
  endtask
  task automatic release1();
    rd_release = 1; @(negedge clk); rd_release = 0;
  endtask
  task automatic fill1(input int base);
    start1();
    for (int i = 0; i < 16; i++) wr1(i, base + i);
  endtask

  task automatic test_reset();
    rst = 1; repeat (2) @(negedge clk); rst = 0;
    checks++; if ({write_complete, err_stray_wr, err_addr, rd_ready, start_ready} !== 5'b00001) begin
      errors++; $display("FAIL reset_flags got %b exp 00001", {write_complete, err_stray_wr, err_addr, rd_ready, start_ready}); end
    checks++; if (d_out !== '0) begin errors++; $display("FAIL reset_dout got %h exp 0", d_out); end
  endtask

  task automatic test_single();
    start1();
    for (int i = 0; i < 15; i++) wr1(i, i);
    checks++; if (write_complete !== 1'b0) begin errors++; $display("FAIL single_early_wc got %b exp 0", write_complete); end
    wr1(15, 15);
    checks++; if ({write_complete, rd_ready} !== 2'b11) begin errors++; $display("FAIL single_done got %b exp 11", {write_complete, rd_ready}); end
    rd1(5, 5);
    checks++; if (write_complete !== 1'b0) begin errors++; $display("FAIL single_wc_pulse got %b exp 0", write_complete); end
    exp_v = q.pop_front(); checks++;
    if (d_out !== exp_v) begin errors++; $display("FAIL single_read got %h exp %h", d_out, exp_v); end
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL single_start_ready got %b exp 1", start_ready); end
  endtask

  task automatic test_pingpong();
    start1();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1; wr_addr = 7'(i); d_in = 512'(32'h100 + i);
      rd_en = 1; rd_addr = 7'(i); q.push_back(512'(i));
      @(negedge clk); wr_en = 0; rd_en = 0;
      exp_v = q.pop_front(); checks++;
      if (d_out !== exp_v) begin errors++; $display("FAIL pp_bank0 addr %0d got %h exp %h", i, d_out, exp_v); end
    end
    checks++; if ({write_complete, start_ready} !== 2'b10) begin errors++; $display("FAIL pp_full got %b exp 10", {write_complete, start_ready}); end
    release1();
    checks++; if ({rd_ready, start_ready} !== 2'b11) begin errors++; $display("FAIL pp_release got %b exp 11", {rd_ready, start_ready}); end
    for (int i = 0; i < 16; i += 5) begin
      rd1(i, 32'h100 + i);
      exp_v = q.pop_front(); checks++;
      if (d_out !== exp_v) begin errors++; $display("FAIL pp_bank1 addr %0d got %h exp %h", i, d_out, exp_v); end
    end
  endtask

  task automatic test_back_pressure();
    fill1(32'h200);
    checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL bp_full got %b exp 0", start_ready); end
    start1();
    repeat (2) @(negedge clk);
    checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL bp_ignored got %b exp 0", start_ready); end
    release1();
    checks++; if ({start_ready, rd_ready} !== 2'b11) begin errors++; $display("FAIL bp_reopen got %b exp 11", {start_ready, rd_ready}); end
    fill1(32'h300);
    checks++; if (write_complete !== 1'b1) begin errors++; $display("FAIL bp_third_wc got %b exp 1", write_complete); end
    rd1(3, 32'h203);
    exp_v = q.pop_front(); checks++;
    if (d_out !== exp_v) begin errors++; $display("FAIL bp_read0 got %h exp %h", d_out, exp_v); end
    release1();
    rd1(7, 32'h307);
    exp_v = q.pop_front(); checks++;
    if (d_out !== exp_v) begin errors++; $display("FAIL bp_read1 got %h exp %h", d_out, exp_v); end
    release1();
    checks++; if ({rd_ready, start_ready} !== 2'b01) begin errors++; $display("FAIL bp_empty got %b exp 01", {rd_ready, start_ready}); end
  endtask

  task automatic test_errors();
    wr1(2, 32'hdead);
    checks++; if ({err_stray_wr, err_addr} !== 2'b10) begin errors++; $display("FAIL err_stray got %b exp 10", {err_stray_wr, err_addr}); end
    rd1(2, 32'h202);
    exp_v = q.pop_front(); checks++;
    if (d_out !== exp_v) begin errors++; $display("FAIL err_ram_kept got %h exp %h", d_out, exp_v); end
    start1();
    for (int i = 0; i < 8; i++) wr1(i, 32'h400 + i);
    wr1(20, 32'hbad);
    checks++; if (err_addr !== 1'b1) begin errors++; $display("FAIL err_addr got %b exp 1", err_addr); end
    for (int i = 8; i < 15; i++) wr1(i, 32'h400 + i);
    checks++; if (write_complete !== 1'b0) begin errors++; $display("FAIL err_not_counted got %b exp 0", write_complete); end
    wr1(15, 32'h40f);
    checks++; if ({write_complete, err_stray_wr} !== 2'b11) begin errors++; $display("FAIL err_complete got %b exp 11", {write_complete, err_stray_wr}); end
    rd1(2, 32'h402);
    exp_v = q.pop_front(); checks++;
    if (d_out !== exp_v) begin errors++; $display("FAIL err_read got %h exp %h", d_out, exp_v); end
    release1();
  endtask

  task automatic test_reset_mid_fill();
    start1();
    for (int i = 0; i < 8; i++) wr1(i, 32'h777);
    rst = 1; @(negedge clk); rst = 0;
    checks++; if ({rd_ready, start_ready, err_stray_wr, err_addr} !== 4'b0100) begin
      errors++; $display("FAIL rst_mid got %b exp 0100", {rd_ready, start_ready, err_stray_wr, err_addr}); end
    start1();
    for (int i = 0; i < 15; i++) wr1(i, 32'h500 + i);
    checks++; if (write_complete !== 1'b0) begin errors++; $display("FAIL rst_recount got %b exp 0", write_complete); end
    wr1(15, 32'h50f);
    checks++; if ({write_complete, rd_ready} !== 2'b11) begin errors++; $display("FAIL rst_refill got %b exp 11", {write_complete, rd_ready}); end
    rd1(15, 32'h50f);
    exp_v = q.pop_front(); checks++;
    if (d_out !== exp_v) begin errors++; $display("FAIL rst_read got %h exp %h", d_out, exp_v); end
  endtask

  task automatic test_same_cycle();
    rst2 = 1; repeat (2) @(negedge clk); rst2 = 0;
    conv_start2 = 1; @(negedge clk); conv_start2 = 0;
    for (int i = 0; i < 9; i++) begin
      wr_en2 = 1; wr_addr2 = 4'(i); d_in2 = 64'(32'ha0 + i); @(negedge clk); wr_en2 = 0;
      if (i == 7) begin
        checks++; if (write_complete2 !== 1'b0) begin errors++; $display("FAIL p2_early_wc got %b exp 0", write_complete2); end
      end
    end
    checks++; if ({write_complete2, rd_ready2} !== 2'b11) begin errors++; $display("FAIL p2_first got %b exp 11", {write_complete2, rd_ready2}); end
    conv_start2 = 1; @(negedge clk); conv_start2 = 0;
    for (int i = 0; i < 9; i++) begin
      wr_en2 = 1; wr_addr2 = 4'(i); d_in2 = 64'(32'hb0 + i);
      rd_release2 = (i == 8);
      @(negedge clk); wr_en2 = 0; rd_release2 = 0;
    end
    checks++; if ({write_complete2, rd_ready2, start_ready2} !== 3'b111) begin
      errors++; $display("FAIL p2_same_cycle got %b exp 111", {write_complete2, rd_ready2, start_ready2}); end
    rd_en2 = 1; rd_addr2 = 4'd8; q.push_back(512'(32'hb8)); @(negedge clk); rd_en2 = 0;
    exp_v = q.pop_front(); checks++;
    if (512'(d_out2) !== exp_v) begin errors++; $display("FAIL p2_read got %h exp %h", d_out2, exp_v); end
  endtask

  initial begin
    {conv_start, wr_en, rd_en, rd_release} = '0; wr_addr = '0; rd_addr = '0; d_in = '0;
    {conv_start2, wr_en2, rd_en2, rd_release2} = '0; wr_addr2 = '0; rd_addr2 = '0; d_in2 = '0;
    rst = 1; rst2 = 1;
    @(negedge clk);
    test_reset();
    test_single();
    test_pingpong();
    test_back_pressure();
    test_errors();
    test_reset_mid_fill();
    test_same_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/layer_input_buffer.md
# layer_input_buffer

Parametrised ping-pong input buffer for a CNN layer boundary. It captures `NUM_WORDS` feature-map words written by the upstream ReLU/pool stage into one bank while the downstream layer reads the other bank. It signals per-bank write completion and provides a start/release handshake so consecutive images overlap. It generalises the fixed single-bank 16×512 layer-6 input stage.

## Interface
- `DATA_W`, default 512: width of one feature word.
- `ADDR_W`, default 7: per-bank address width. Bank depth is 2^ADDR_W.
- `NUM_WORDS`, default 16: words per image. Legal range is 1 ≤ `NUM_WORDS` ≤ 2^ADDR_W.
- `clk`, in, 1: the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `conv_start`, in, 1: arms filling of the current write bank.
- `start_ready`, out, 1: a `conv_start` in this cycle will be accepted.
- `wr_en`, in, 1: write strobe.
- `wr_addr`, in, ADDR_W: word index within the write bank.
- `d_in`, in, DATA_W: write data.
- `write_complete`, out, 1: one-cycle pulse when a bank finishes filling.
- `rd_ready`, out, 1: the read bank holds a complete image.
- `rd_en`, in, 1: read strobe.
- `rd_addr`, in, ADDR_W: word index within the read bank.
- `d_out`, out, DATA_W: registered read data.
- `rd_release`, in, 1: consumer is finished with the read bank.
- `err_stray_wr`, out, 1: sticky flag, set by a `wr_en` outside FILL.
- `err_addr`, out, 1: sticky flag, set by a `wr_addr` ≥ `NUM_WORDS` during FILL.

## Operation
- Storage is two banks. Physical RAM address is {bank, addr}, 2·2^ADDR_W words in total.
- Internal registers:
  - `wr_bank` and `rd_bank` pointers, both reset to 0.
  - `valid[1:0]`, reset to 0.
  - `wr_count`, width clog2(NUM_WORDS+1).
- Write FSM has two states, IDLE and FILL.
- `start_ready` = (state==IDLE) && !valid[wr_bank]. It is combinational.
- IDLE:
  - `conv_start` && `start_ready` → FILL, with `wr_count` ← 0.
  - `conv_start` without `start_ready` is ignored. The producer must hold or retry it.
- FILL:
  - `wr_en` with `wr_addr` < `NUM_WORDS` writes `d_in` to {wr_bank, wr_addr} and increments `wr_count`.
  - On the accepted write that makes `wr_count` reach `NUM_WORDS`:
    - `write_complete` pulses;
    - valid[wr_bank] ← 1;
    - `wr_bank` toggles;
    - state returns to IDLE.
  - `conv_start` during FILL is ignored.
- Writes are counted, not address-checked for duplicates. A duplicate address overwrites and still counts.
- Invalid `wr_addr` in FILL: no RAM write, not counted, `err_addr` ← 1.
- `wr_en` in IDLE: no RAM write, `err_stray_wr` ← 1.
- Read side:
  - `rd_ready` = valid[rd_bank].
  - `rd_en` reads {rd_bank, rd_addr} regardless of `rd_ready`, which allows debug reads.
  - `d_out` holds its value when `rd_en` is low.
- `rd_release` && `rd_ready`: valid[rd_bank] ← 0 and `rd_bank` toggles. `rd_release` without `rd_ready` is ignored.
- Completion and release in the same cycle always target different banks. Both updates to `valid` apply.

## Timing
- Reset values:
  - `write_complete`=0, `err_*`=0, `d_out`=0;
  - `start_ready`=1, `rd_ready`=0;
  - FSM in IDLE, pointers at 0, `valid`=0.
  - RAM contents are not cleared.
- Reset asserted mid-FILL aborts the image: partial data is discarded and both banks are invalid.
- `conv_start` accepted at edge N puts the FSM in FILL from N+1. A `wr_en` in the same cycle as `conv_start` counts as stray.
- `write_complete` is high for exactly the cycle after the final accepted write edge. `rd_ready` rises in that same cycle if that bank is the read bank.
- Read latency is 1 cycle: `rd_en` at edge N gives `d_out` valid after edge N.
- A read in the same cycle as a write to the same physical address returns the old data (read-first).
- Once both banks are valid, `start_ready`=0. It returns to 1 the cycle after a `rd_release`.
- Steady state allows one image filling while the other is being read, with zero bubble.

## Structure
- Shared package `cnn_buf_pkg`: FSM state encoding (IDLE=0, FILL=1) and a `clog2` helper.
- One sub-module, `layer_buf_ram`:
  - simple dual-port RAM, 2^(ADDR_W+1) × DATA_W;
  - synchronous write and registered read-first read port, no reset on the array.
- Top level holds the FSM, counter, bank pointers, `valid` bits and error flags.

## Test plan
- **Single image:** reset, `conv_start`, then 16 writes of data=addr to addrs 0–15 → `write_complete` pulse one cycle after the 16th write, `rd_ready`=1, reading addr 5 gives 5 one cycle later.
- **Ping-pong overlap:** fill bank0; start image 2 and write 0x100+addr while reading bank0 → reads return addr values; after `rd_release`, reads return 0x100+addr.
- **Back-pressure:** fill two images without release → `start_ready`=0 and a third `conv_start` is ignored. After one `rd_release`, `start_ready`=1 next cycle and the third image is accepted.
- **Errors:**
  - `wr_en` in IDLE → `err_stray_wr`=1, RAM unchanged.
  - `wr_addr`=20 with `NUM_WORDS`=16 → `err_addr`=1 and no count; image still completes after 16 valid writes.
- **Reset mid-FILL:** after 8 writes, pulse `rst` → `rd_ready`=0, `start_ready`=1. A new full image completes normally.
- **Parametrisation and same-cycle events:** `DATA_W`=64, `ADDR_W`=4, `NUM_WORDS`=9, final write and `rd_release` in the same cycle → both `valid` updates apply, `write_complete` after 9 writes.
